// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, FSM state encoding and the byte-selection helper
// for the LCD rectangle-fill sequencer.
//   CMD_CASET / CMD_PASET / CMD_RAMWR : controller command opcodes
//   DEFAULT_COLS / DEFAULT_ROWS       : default panel geometry (240 x 320)
//   state_t                           : sequencer FSM states
//   byte_for()                        : {dc, data} presented in a given state
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEFAULT_COLS = 240;
    localparam int DEFAULT_ROWS = 320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_CMD,
        ST_CASET_DAT,
        ST_PASET_CMD,
        ST_PASET_DAT,
        ST_RAMWR_CMD,
        ST_PIX_HI,
        ST_PIX_LO
    } state_t;

    // Address window bytes: start then end, each zero-extended to 16 bits, MSB first.
    function automatic logic [7:0] coord_byte(input logic [8:0] lo, input logic [8:0] hi,
                                              input logic [1:0] idx);
        case (idx)
            2'd0:    coord_byte = {7'b0, lo[8]};
            2'd1:    coord_byte = lo[7:0];
            2'd2:    coord_byte = {7'b0, hi[8]};
            default: coord_byte = hi[7:0];
        endcase
    endfunction

    // Returns {dc, data}; dc=0 for commands, 1 for parameters and pixels.
    function automatic logic [8:0] byte_for(input state_t st, input logic [1:0] idx,
                                            input logic [8:0] x0, input logic [8:0] x1,
                                            input logic [8:0] y0, input logic [8:0] y1,
                                            input logic [15:0] color);
        case (st)
            ST_CASET_CMD: byte_for = {1'b0, CMD_CASET};
            ST_CASET_DAT: byte_for = {1'b1, coord_byte(x0, x1, idx)};
            ST_PASET_CMD: byte_for = {1'b0, CMD_PASET};
            ST_PASET_DAT: byte_for = {1'b1, coord_byte(y0, y1, idx)};
            ST_RAMWR_CMD: byte_for = {1'b0, CMD_RAMWR};
            ST_PIX_HI:    byte_for = {1'b1, color[15:8]};
            ST_PIX_LO:    byte_for = {1'b1, color[7:0]};
            default:      byte_for = 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/lcd_rect_counter.sv
// lcd_rect_counter: walks a rectangle column-first, row-second.
//   clk, rst            : clock, asynchronous active-high reset
//   load_i              : start a new rectangle at (load_col_i, load_row_i)
//   step_i              : advance to the next pixel
//   col_first_i         : column reloaded on wrap
//   col_last_i          : last column of the rectangle
//   row_last_i          : last row of the rectangle
//   last_o              : current pixel is the final one
module lcd_rect_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [8:0] load_col_i,
    input  logic [8:0] load_row_i,
    input  logic       step_i,
    input  logic [8:0] col_first_i,
    input  logic [8:0] col_last_i,
    input  logic [8:0] row_last_i,
    output logic       last_o
);

    logic [8:0] col_q;
    logic [8:0] row_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (load_i) begin
            col_q <= load_col_i;
            row_q <= load_row_i;
        end else if (step_i) begin
            if (col_q < col_last_i) begin
                col_q <= col_q + 9'd1;
            end else begin
                col_q <= col_first_i;
                row_q <= row_q + 9'd1;
            end
        end
    end

    assign last_o = (col_q == col_last_i) && (row_q == row_last_i);

endmodule

// File: rtl/lcd_fill_sequencer.sv
// lcd_fill_sequencer: turns a rectangle-fill request into the LCD byte stream
// CASET(x0,x1), PASET(y0,y1), RAMWR, then one RGB565 colour per pixel.
//   clk, rst                 : clock, asynchronous active-high reset
//   en                       : byte-rate enable; bytes are consumed only when en=1
//   req_valid / req_ready    : request handshake (ready only while idle)
//   x0,x1,y0,y1,color        : inclusive rectangle and fill colour
//   byte_start/data/dc       : pending byte for the SPI byte engine
//   byte_done                : engine finished the pending byte
//   busy                     : fill in progress
//   err                      : one-cycle pulse after a rejected request
module lcd_fill_sequencer
    import lcd_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    output logic        byte_start,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    input  logic        byte_done,
    output logic        busy,
    output logic        err
);

    localparam logic [9:0] COLS_LIM = 10'(COLS);
    localparam logic [9:0] ROWS_LIM = 10'(ROWS);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [8:0]  x0_q, x1_q, y0_q, y1_q;
    logic [15:0] color_q;
    logic [7:0]  byte_data_q;
    logic        byte_dc_q;
    logic        err_q, err_d;
    logic [8:0]  byte_next;

    logic accept;
    logic req_ok;
    logic consume;
    logic cnt_load;
    logic cnt_step;
    logic last_pix;

    assign req_ok  = (x0 <= x1) && (y0 <= y1) &&
                     ({1'b0, x1} < COLS_LIM) && ({1'b0, y1} < ROWS_LIM);
    assign consume = en && byte_done && (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_ok) begin
                        state_d  = ST_CASET_CMD;
                        cnt_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CASET_CMD: if (consume) begin
                state_d = ST_CASET_DAT;
                idx_d   = 2'd0;
            end
            // idx wraps 3 -> 0 on the last parameter byte, ready for the next window.
            ST_CASET_DAT: if (consume) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ST_PASET_CMD;
            end
            ST_PASET_CMD: if (consume) begin
                state_d = ST_PASET_DAT;
                idx_d   = 2'd0;
            end
            ST_PASET_DAT: if (consume) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ST_RAMWR_CMD;
            end
            ST_RAMWR_CMD: if (consume) state_d = ST_PIX_HI;
            ST_PIX_HI:    if (consume) state_d = ST_PIX_LO;
            ST_PIX_LO: if (consume) begin
                cnt_step = 1'b1;
                state_d  = last_pix ? ST_IDLE : ST_PIX_HI;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The byte for the next state is registered, so outputs stay put until consumed.
    // Coordinates are only read in _DAT states, by which time they are registered.
    assign byte_next = byte_for(state_d, idx_d, x0_q, x1_q, y0_q, y1_q, color_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            byte_data_q <= '0;
            byte_dc_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            byte_dc_q   <= byte_next[8];
            byte_data_q <= byte_next[7:0];
            if (accept) begin
                x0_q    <= x0;
                x1_q    <= x1;
                y0_q    <= y0;
                y1_q    <= y1;
                color_q <= color;
            end
        end
    end

    lcd_rect_counter u_rect (
        .clk         (clk),
        .rst         (rst),
        .load_i      (cnt_load),
        .load_col_i  (x0),
        .load_row_i  (y0),
        .step_i      (cnt_step),
        .col_first_i (x0_q),
        .col_last_i  (x1_q),
        .row_last_i  (y1_q),
        .last_o      (last_pix)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign byte_start = (state_q != ST_IDLE);
    assign byte_data  = byte_data_q;
    assign byte_dc    = byte_dc_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
module tb_lcd_fill_sequencer;

    logic        clk = 1'b0;
    logic        rst, en, req_valid, byte_done;
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color;
    logic        req_ready, byte_start, byte_dc, busy, err;
    logic [7:0]  byte_data;

    lcd_fill_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .byte_start(byte_start), .byte_data(byte_data), .byte_dc(byte_dc),
        .byte_done(byte_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int mode    = 0;
    int en_cnt  = 0;

    logic [8:0] cap[$];
    logic [8:0] exp_q[$];
    int   err_cnt, start_cnt, stab_viol;
    logic prev_start, prev_cons;
    logic [8:0] prev_byte;

    task automatic check(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Byte-engine emulation: en / byte_done patterns per mode.
    initial begin
        en = 1'b0;
        byte_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: begin en = 1'b1; byte_done = 1'b1; end
                1: begin en = 1'($urandom % 2); byte_done = (($urandom % 3) != 0); end
                2: begin en = ~en; byte_done = 1'b1; end
                default: begin en = 1'b1; en_cnt++; byte_done = ((en_cnt % 4) == 0); end
            endcase
        end
    end

    // Monitor: captures consumed bytes, counts err/start cycles, checks byte stability.
    initial begin
        prev_start = 1'b0;
        prev_cons  = 1'b0;
        prev_byte  = '0;
        err_cnt = 0; start_cnt = 0; stab_viol = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 1'b0;
                prev_cons  = 1'b0;
            end else begin
                if (err) err_cnt++;
                if (byte_start) start_cnt++;
                if (prev_start && !prev_cons && byte_start && ({byte_dc, byte_data} != prev_byte))
                    stab_viol++;
                prev_cons = byte_start && en && byte_done;
                if (prev_cons) cap.push_back({byte_dc, byte_data});
                prev_start = byte_start;
                prev_byte  = {byte_dc, byte_data};
            end
        end
    end

    // Reference model: the byte list the panel should see for a rectangle.
    function automatic logic [8:0] dbyte(input int v);
        return {1'b1, 8'(v)};
    endfunction

    task automatic build_exp(input int a0, input int a1, input int b0, input int b1, input int c);
        int npix;
        exp_q.delete();
        exp_q.push_back(9'h02A);
        exp_q.push_back(dbyte(a0 / 256)); exp_q.push_back(dbyte(a0 % 256));
        exp_q.push_back(dbyte(a1 / 256)); exp_q.push_back(dbyte(a1 % 256));
        exp_q.push_back(9'h02B);
        exp_q.push_back(dbyte(b0 / 256)); exp_q.push_back(dbyte(b0 % 256));
        exp_q.push_back(dbyte(b1 / 256)); exp_q.push_back(dbyte(b1 % 256));
        exp_q.push_back(9'h02C);
        npix = (a1 - a0 + 1) * (b1 - b0 + 1);
        for (int p = 0; p < npix; p++) begin
            exp_q.push_back(dbyte(c / 256));
            exp_q.push_back(dbyte(c % 256));
        end
    endtask

    task automatic do_req(input string name, input int a0, input int a1, input int b0, input int b1,
                          input int c, input int m, input bit inj,
                          output int got_err, output int got_n);
        bit ok;
        int k, bad, rdy_viol;
        mode = m;
        ok = (a0 <= a1) && (b0 <= b1) && (a1 < 240) && (b1 < 320);
        if (ok) build_exp(a0, a1, b0, b1, c);
        else exp_q.delete();
        k = 0;
        while (!req_ready && k < 5000) begin wait_neg(); k++; end
        check({name, " ready_wait"}, int'(req_ready), 1);
        @(posedge clk);
        #2;
        x0 = 9'(a0); x1 = 9'(a1); y0 = 9'(b0); y1 = 9'(b1); color = 16'(c);
        req_valid = 1'b1;
        cap.delete();
        err_cnt = 0; start_cnt = 0; stab_viol = 0; rdy_viol = 0;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        x0 = 9'($urandom); x1 = 9'($urandom); y0 = 9'($urandom); y1 = 9'($urandom);
        color = 16'($urandom);
        wait_neg();
        if (ok) begin
            check({name, " first_byte_latency"}, int'(byte_start), 1);
            k = 0;
            while (busy && k < 20000) begin
                wait_neg();
                if (inj && k == 6) begin
                    req_valid = 1'b1; x0 = 9'd1; x1 = 9'd2; y0 = 9'd1; y1 = 9'd2;
                end
                if (inj && k == 30) req_valid = 1'b0;
                if (req_valid && req_ready) rdy_viol++;
                k++;
            end
            req_valid = 1'b0;
            check({name, " busy_timeout"}, int'(busy), 0);
            check({name, " byte_count"}, cap.size(), exp_q.size());
            bad = -1;
            for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
                if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
            if (bad >= 0)
                $display("FAIL %s byte[%0d]: got dc/data %03h required %03h", name, bad, cap[bad], exp_q[bad]);
            check({name, " first_bad_index"}, bad, -1);
            check({name, " stability"}, stab_viol, 0);
            check({name, " no_err"}, err_cnt, 0);
            if (inj) check({name, " ready_low_midfill"}, rdy_viol, 0);
        end else begin
            check({name, " err_ready_next"}, int'(req_ready), 1);
            repeat (3) wait_neg();
            check({name, " err_pulses"}, err_cnt, 1);
            check({name, " no_start"}, start_cnt, 0);
            check({name, " no_bytes"}, cap.size(), 0);
        end
        got_err = err_cnt;
        got_n   = cap.size();
        $display("txn %-12s (%0d,%0d)-(%0d,%0d) color=%04h mode=%0d -> bytes=%0d err=%0d",
                 name, a0, b0, a1, b1, c, m, got_n, got_err);
    endtask

    typedef struct {
        string nm;
        int a0, a1, b0, b1, c, m;
        int exp_err, exp_n;
    } vec_t;

    vec_t vt[7];

    initial begin
        int ge, gn, a0, a1, b0, b1, w, h, cnt;
        logic [8:0] hdr[11];
        rst = 1'b1; req_valid = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        repeat (3) wait_neg();
        check("rst req_ready", int'(req_ready), 1);
        check("rst byte_start", int'(byte_start), 0);
        check("rst byte_data", int'(byte_data), 0);
        check("rst byte_dc", int'(byte_dc), 0);
        check("rst busy", int'(busy), 0);
        check("rst err", int'(err), 0);
        @(posedge clk); #2; rst = 1'b0;

        vt[0] = '{"px_f800",   0,   0,   0,   0, 'hF800, 3, 0, 13};
        vt[1] = '{"rect_07e0", 10,  13,  20,  21, 'h07E0, 1, 0, 27};
        vt[2] = '{"bad_x0x1",  5,   4,   0,   0, 'h1111, 0, 1, 0};
        vt[3] = '{"bad_x240",  0,   240, 0,   0, 'h2222, 0, 1, 0};
        vt[4] = '{"bad_y320",  0,   0,   0,   320, 'h3333, 0, 1, 0};
        vt[5] = '{"corner",    239, 239, 319, 319, 'hFFFF, 1, 0, 13};
        vt[6] = '{"row_pair",  0,   1,   5,   5, 'h1234, 0, 0, 15};
        for (int i = 0; i < 7; i++) begin
            do_req(vt[i].nm, vt[i].a0, vt[i].a1, vt[i].b0, vt[i].b1, vt[i].c, vt[i].m, 1'b0, ge, gn);
            check({vt[i].nm, " tbl_err"}, ge, vt[i].exp_err);
            check({vt[i].nm, " tbl_n"}, gn, vt[i].exp_n);
        end

        // Mid-fill request ignored, byte_done held high with en toggling.
        do_req("inject", 3, 6, 7, 10, 'hA5C3, 2, 1'b1, ge, gn);

        // Randomised rectangles, some deliberately out of range.
        for (int i = 0; i < 20; i++) begin
            w  = $urandom_range(1, 6);
            h  = $urandom_range(1, 6);
            a0 = $urandom_range(0, 240 - w);
            b0 = $urandom_range(0, 320 - h);
            a1 = a0 + w - 1;
            b1 = b0 + h - 1;
            if (i % 5 == 4) b1 = $urandom_range(320, 511);
            if (i % 7 == 6 && a0 > 0) begin a1 = a0 - 1; end
            do_req("random", a0, a1, b0, b1, int'($urandom % 65536), 1, 1'b0, ge, gn);
        end

        // Full-screen fill: header bytes, then asynchronous abort at pixel 100.
        mode = 0;
        hdr = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
        @(posedge clk); #2;
        x0 = 9'd0; x1 = 9'd239; y0 = 9'd0; y1 = 9'd319; color = 16'h5555;
        req_valid = 1'b1;
        cap.delete();
        @(posedge clk); #2;
        req_valid = 1'b0;
        cnt = 0;
        while (cap.size() < 211 && cnt < 2000) begin wait_neg(); cnt++; end
        check("full header+100px reached", int'(cap.size() >= 211), 1);
        for (int i = 0; i < 11; i++) begin
            if (cap.size() > i) check($sformatf("full hdr[%0d]", i), int'(cap[i]), int'(hdr[i]));
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort byte_start", int'(byte_start), 0);
        check("abort byte_data", int'(byte_data), 0);
        check("abort req_ready", int'(req_ready), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        start_cnt = 0;
        repeat (5) wait_neg();
        check("no resume after abort", start_cnt, 0);
        $display("txn %-12s full-screen aborted after %0d bytes", "abort", cap.size());
        do_req("post_abort", 7, 7, 9, 9, 'h0F0F, 0, 1'b0, ge, gn);
        check("post_abort total", gn, 13);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
